// File: rtl/riscv_wb_pkg.sv
// Shared types and helpers for the writeback stage.
package riscv_wb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RF_IDX_W = $clog2(DATA_W);

  // One buffered result at the default data width: destination index plus value.
  typedef struct packed {
    logic [RF_IDX_W-1:0] rd;
    logic [DATA_W-1:0]   data;
  } wb_entry_t;

  // The load buffer needs a power-of-two depth of at least two so the
  // extra-bit pointer scheme wraps cleanly.
  function automatic bit ld_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO used as the load result buffer.
// Pointers carry one extra wrap bit so that count = wr_ptr - rd_ptr.
module wb_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  T            mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  // Pointer update; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_writeback.sv
// Writeback stage: merges the non-stallable ALU result with buffered load
// results onto the single register-file write port. ALU has priority.
// Optional operand forwarding is enabled by defining WB_FWD_EN.
module rf_writeback
  import riscv_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LD_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [$clog2(DATA_WIDTH)-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [$clog2(DATA_WIDTH)-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic                          rf1_wr_en,
  output logic [$clog2(DATA_WIDTH)-1:0] rf1_wr_index,
  output logic [DATA_WIDTH-1:0]         rf1_wr_data,
  output logic [$clog2(LD_DEPTH):0]     wb_pending,
  output logic                          wb_busy
`ifdef WB_FWD_EN
  ,
  input  logic [$clog2(DATA_WIDTH)-1:0] fwd_idx1,
  input  logic [$clog2(DATA_WIDTH)-1:0] fwd_idx2,
  output logic                          fwd1_hit,
  output logic [DATA_WIDTH-1:0]         fwd1_data,
  output logic                          fwd2_hit,
  output logic [DATA_WIDTH-1:0]         fwd2_data
`endif
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  if (!ld_depth_ok(LD_DEPTH)) begin : g_bad_depth
    $error("rf_writeback: LD_DEPTH must be a power of two and at least 2");
  end

  // Same layout as wb_entry_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [IDX_W-1:0]      rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                  ld_in;
  entry_t                  ld_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    sel_valid;
  logic [IDX_W-1:0]        sel_rd;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign ld_in.rd   = ld_rd;
  assign ld_in.data = ld_data;

  // ld_ready depends only on registered occupancy.
  assign ld_ready = !fifo_full;
  assign push     = ld_valid && ld_ready && !reset;
  assign pop      = !alu_valid && !fifo_empty;

  wb_fifo #(
    .T     (entry_t),
    .DEPTH (LD_DEPTH)
  ) u_ld_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ld_in),
    .pop   (pop),
    .dout  (ld_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (wb_pending)
  );

  // Source select: ALU first, otherwise the buffer head.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = ld_head.rd;
      sel_data  = ld_head.data;
    end
  end

  // Output register; x0 writes are dropped and index/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf1_wr_en    <= 1'b0;
      rf1_wr_index <= '0;
      rf1_wr_data  <= '0;
    end else if (sel_valid && (sel_rd != '0)) begin
      rf1_wr_en    <= 1'b1;
      rf1_wr_index <= sel_rd;
      rf1_wr_data  <= sel_data;
    end else begin
      rf1_wr_en    <= 1'b0;
    end
  end

  assign wb_busy = (wb_pending != '0) || rf1_wr_en;

`ifdef WB_FWD_EN
  // Bypass the write landing at the end of this cycle to decode.
  always_comb begin
    fwd1_hit  = rf1_wr_en && (rf1_wr_index == fwd_idx1) && (fwd_idx1 != '0);
    fwd2_hit  = rf1_wr_en && (rf1_wr_index == fwd_idx2) && (fwd_idx2 != '0);
    fwd1_data = rf1_wr_data;
    fwd2_data = rf1_wr_data;
  end
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Directed, table-driven bench for rf_writeback (LD_DEPTH = 4).
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf1_wr_en;
  logic [4:0]  rf1_wr_index;
  logic [31:0] rf1_wr_data;
  logic [2:0]  wb_pending;
  logic        wb_busy;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_idx1;
  logic [4:0]  fwd_idx2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_writeback #(
    .DATA_WIDTH (32),
    .LD_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .rf1_wr_en    (rf1_wr_en),
    .rf1_wr_index (rf1_wr_index),
    .rf1_wr_data  (rf1_wr_data),
    .wb_pending   (wb_pending),
    .wb_busy      (wb_busy)
`ifdef WB_FWD_EN
    ,
    .fwd_idx1     (fwd_idx1),
    .fwd_idx2     (fwd_idx2),
    .fwd1_hit     (fwd1_hit),
    .fwd1_data    (fwd1_data),
    .fwd2_hit     (fwd2_hit),
    .fwd2_data    (fwd2_data)
`endif
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_en;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
    logic [2:0]  e_pend;
    logic        e_rdy;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=0x%0h want=0x%0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic en, input logic [4:0] idx, input logic [31:0] data,
                     input logic [2:0] pend, input logic rdy, input logic busy);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.e_en = en; v.e_idx = idx; v.e_data = data;
    v.e_pend = pend; v.e_rdy = rdy; v.e_busy = busy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
  endtask

  // Apply current inputs across one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_cyc;
    int last_cyc;
    int seen;
    logic [4:0] got_idx[$];

    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
`ifdef WB_FWD_EN
    fwd_idx1 = '0;
    fwd_idx2 = '0;
`endif

    //   rst av ard  adat          lv lrd  ldat        en idx  data          pend rdy busy
    add(1, 0, 0,  32'h0,        0, 0,  32'h0,       0, 0,  32'h0,        0, 1, 0); // reset
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 0,  32'h0,        0, 1, 0);
    add(0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,       1, 5,  32'hDEADBEEF, 0, 1, 1); // ALU only
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 5,  32'hDEADBEEF, 0, 1, 0);
    add(0, 0, 0,  32'h0,        1, 7,  32'h1234,    0, 5,  32'hDEADBEEF, 1, 1, 1); // load accept
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       1, 7,  32'h1234,     0, 1, 1);
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 7,  32'h1234,     0, 1, 0);
    add(0, 1, 10, 32'hA0,       1, 1,  32'h101,     1, 10, 32'hA0,       1, 1, 1); // priority/fill
    add(0, 1, 11, 32'hA1,       1, 2,  32'h102,     1, 11, 32'hA1,       2, 1, 1);
    add(0, 1, 12, 32'hA2,       1, 3,  32'h103,     1, 12, 32'hA2,       3, 1, 1);
    add(0, 1, 13, 32'hA3,       1, 4,  32'h104,     1, 13, 32'hA3,       4, 0, 1);
    add(0, 1, 14, 32'hA4,       1, 5,  32'h105,     1, 14, 32'hA4,       4, 0, 1);
    add(0, 1, 15, 32'hA5,       1, 5,  32'h105,     1, 15, 32'hA5,       4, 0, 1);
    add(0, 0, 0,  32'h0,        1, 5,  32'h105,     1, 1,  32'h101,      3, 1, 1); // pop while full
    add(0, 0, 0,  32'h0,        1, 5,  32'h105,     1, 2,  32'h102,      3, 1, 1); // push+pop
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       1, 3,  32'h103,      2, 1, 1);
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       1, 4,  32'h104,      1, 1, 1);
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       1, 5,  32'h105,      0, 1, 1);
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 5,  32'h105,      0, 1, 0);
    add(0, 1, 0,  32'h55,       0, 0,  32'h0,       0, 5,  32'h105,      0, 1, 0); // x0 ALU
    add(0, 0, 0,  32'h0,        1, 0,  32'h66,      0, 5,  32'h105,      1, 1, 1); // x0 load
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 5,  32'h105,      0, 1, 0);
    add(0, 1, 0,  32'h77,       1, 0,  32'h88,      0, 5,  32'h105,      1, 1, 1);
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 5,  32'h105,      0, 1, 0);
    add(0, 1, 8,  32'h88,       1, 20, 32'h200,     1, 8,  32'h88,       1, 1, 1); // fill 3
    add(0, 1, 8,  32'h89,       1, 21, 32'h201,     1, 8,  32'h89,       2, 1, 1);
    add(0, 1, 8,  32'h8A,       1, 22, 32'h202,     1, 8,  32'h8A,       3, 1, 1);
    add(1, 1, 8,  32'h8B,       1, 23, 32'h203,     0, 0,  32'h0,        0, 1, 0); // reset mid-drain
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 0,  32'h0,        0, 1, 0);
    add(0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 0,  32'h0,        0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat,
            vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      step();
      chk("wr_en",    i, 32'(rf1_wr_en),    32'(vecs[i].e_en));
      chk("wr_index", i, 32'(rf1_wr_index), 32'(vecs[i].e_idx));
      chk("wr_data",  i, rf1_wr_data,       vecs[i].e_data);
      chk("pending",  i, 32'(wb_pending),   32'(vecs[i].e_pend));
      chk("ld_ready", i, 32'(ld_ready),     32'(vecs[i].e_rdy));
      chk("busy",     i, 32'(wb_busy),      32'(vecs[i].e_busy));
    end

    // Full buffer drains in LD_DEPTH consecutive ALU-idle cycles, in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'(11 + i), 32'h300 + i);
      step();
    end
    drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd30, 32'h3FF);
    step();
    chk("full_ready", 100, 32'(ld_ready), 32'd0);
    chk("full_pend",  100, 32'(wb_pending), 32'd4);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (rf1_wr_en) begin
        got_idx.push_back(rf1_wr_index);
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
    end
    chk("drain_count", 101, 32'(got_idx.size()), 32'd4);
    chk("drain_span",  101, 32'(last_cyc - first_cyc), 32'd3);
    chk("drain_first", 101, 32'(first_cyc), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < got_idx.size()) chk("drain_order", 102 + k, 32'(got_idx[k]), 32'(11 + k));
      else                    chk("drain_order", 102 + k, 32'hFFFF_FFFF, 32'(11 + k));
    end
    chk("drain_pend", 106, 32'(wb_pending), 32'd0);

    // Single load to rd 9, waited for with a bounded budget.
`ifdef WB_FWD_EN
    fwd_idx1 = 5'd9;
    fwd_idx2 = 5'd0;
`endif
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    seen = 0;
    for (int c = 0; c < 8 && seen == 0; c++) begin
      step();
      if (rf1_wr_en) seen = 1;
    end
    chk("ld9_seen", 110, 32'(seen), 32'd1);
    if (seen == 1) begin
      chk("ld9_index", 111, 32'(rf1_wr_index), 32'd9);
      chk("ld9_data",  112, rf1_wr_data, 32'h99);
`ifdef WB_FWD_EN
      chk("fwd1_hit",  113, 32'(fwd1_hit), 32'd1);
      chk("fwd1_data", 114, fwd1_data, 32'h99);
      chk("fwd2_hit",  115, 32'(fwd2_hit), 32'd0);
      step();
      chk("fwd1_idle", 116, 32'(fwd1_hit), 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
